reg_file_2r2w_sb: RTL and testbench
===================================

REG_FILE_2R2W_SB -- requirements
Module: reg_file_2r2w_sb

Interface
REQ-001 SHALL have parameter DATA_W, default 16, register width in bits.
REQ-002 SHALL have parameter ADDR_W, default 3, address width; depth = 2**ADDR_W.
REQ-003 SHALL have parameter R0_ZERO, default 0; when 1, register 0 is hardwired to zero.
REQ-004 SHALL have parameter BYPASS, default 1; when 1, same-cycle write data is forwarded to the read ports.
REQ-005 SHALL have port clk, input, 1, the single clock; all state updates on its rising edge.
REQ-006 SHALL have port rst, input, 1, synchronous, active-high reset.
REQ-007 SHALL have ports wr0_en, input, 1, and wr1_en, input, 1, the write-port enables.
REQ-008 SHALL have ports wr0_addr and wr1_addr, input, ADDR_W, the write addresses.
REQ-009 SHALL have ports wr0_data and wr1_data, input, DATA_W, the write data.
REQ-010 SHALL have ports rd0_addr and rd1_addr, input, ADDR_W, the read addresses.
REQ-011 SHALL have ports rd0_data and rd1_data, output, DATA_W, the read data.
REQ-012 SHALL have ports rd0_busy and rd1_busy, output, 1, the scoreboard bit of the addressed register.
REQ-013 SHALL have port bsy_set_en, input, 1, which marks a register pending.
REQ-014 SHALL have port bsy_set_addr, input, ADDR_W, the register to mark pending.

Function
REQ-015 Storage SHALL be 2**ADDR_W registers of DATA_W bits; busy SHALL be one bit per register.
REQ-016 When wrN_en=1, register wrN_addr SHALL load wrN_data at the next edge.
REQ-017 When both write ports target the same address, wr1 SHALL win.
REQ-018 Reads SHALL be combinational: rdN_data = reg[rdN_addr] and rdN_busy = busy[rdN_addr].
REQ-019 BYPASS=1: if rdN_addr matches an enabled write address, rdN_data SHALL be that write data, with wr1 having priority.
REQ-020 BYPASS=1: rdN_busy SHALL read 0 when the addressed register is being written this cycle and not being set this cycle.
REQ-021 BYPASS=0: the read ports SHALL return pre-edge register and busy contents (old data).
REQ-022 bsy_set_en=1 SHALL set busy[bsy_set_addr] at the next edge.
REQ-023 Any enabled write to an address SHALL clear its busy bit at the next edge.
REQ-024 When a set and a clear target the same address in one cycle, the set SHALL win (new producer issued).
REQ-025 R0_ZERO=1: writes to address 0 SHALL be ignored, reads SHALL return 0, busy[0] SHALL stay 0, and no bypass SHALL apply to address 0.
REQ-026 Out-of-range behaviour is not applicable because the depth is an exact power of two.

Reset
REQ-027 While rst=1 at an edge, all registers and all busy bits SHALL become 0, overriding any write or set in that cycle.
REQ-028 After reset, rd0_data, rd1_data, rd0_busy and rd1_busy SHALL read 0 for every address; with BYPASS=1 this holds only while no write is present.
REQ-029 Reset asserted mid-sequence SHALL discard pending busy state; no write SHALL complete in the reset cycle.

Structure
REQ-030 Package rf_pkg SHALL hold the DATA_W and ADDR_W defaults and a function computing depth.
REQ-031 One sub-module, rf_read_port, SHALL implement the address mux, the bypass compare and busy selection; it SHALL be instantiated twice.
REQ-032 Storage SHALL be a parametrised array, not discrete named registers.

Verification
REQ-033 Reset, then read all 8 addresses on both ports -> data 0x0000, busy 0.
REQ-034 Write 0xBEEF to r3 on wr0 and 0x1234 to r3 on wr1 in the same cycle -> r3 = 0x1234 next cycle.
REQ-035 BYPASS=1: write 0xA5A5 to r5 with rd0_addr=5 in the same cycle -> rd0_data = 0xA5A5 combinationally; with BYPASS=0 -> old value.
REQ-036 Set busy r2; next cycle rd1_busy=1; write r2=0x0042 -> busy 0 the following cycle, data 0x0042.
REQ-037 Set busy r6 and write r6 in the same cycle -> busy[6]=1 afterward; R0_ZERO=1 with a write of 0xFFFF to r0 -> reads 0.
REQ-038 Set busy r1 and r4, assert rst with a concurrent write r1=0x7777 -> all data and busy are 0 after the edge.

Source files
------------

// File: rtl/rf_pkg.sv
// Shared defaults and helpers for the 2-read/2-write register file
// with busy scoreboard.
package rf_pkg;

    localparam int DATA_W_DEF = 16;
    localparam int ADDR_W_DEF = 3;

    function automatic int rf_depth(input int aw);
        return 1 << aw;
    endfunction

endpackage

// File: rtl/rf_read_port.sv
// One read port: register/busy select, same-cycle write forwarding
// and the hardwired-zero override for register 0.
module rf_read_port
    import rf_pkg::*;
#(
    parameter int DATA_W  = DATA_W_DEF,
    parameter int ADDR_W  = ADDR_W_DEF,
    parameter bit R0_ZERO = 1'b0,
    parameter bit BYPASS  = 1'b1,
    parameter int DEPTH   = rf_depth(ADDR_W)
) (
    input  logic [DEPTH-1:0][DATA_W-1:0] regs,
    input  logic [DEPTH-1:0]             busy_vec,
    input  logic [ADDR_W-1:0]            addr,
    input  logic                         wr0_en,
    input  logic [ADDR_W-1:0]            wr0_addr,
    input  logic [DATA_W-1:0]            wr0_data,
    input  logic                         wr1_en,
    input  logic [ADDR_W-1:0]            wr1_addr,
    input  logic [DATA_W-1:0]            wr1_data,
    input  logic                         set_en,
    input  logic [ADDR_W-1:0]            set_addr,
    output logic [DATA_W-1:0]            data,
    output logic                         busy
);

    logic hit0;
    logic hit1;
    logic set_hit;

    assign hit0    = wr0_en && (wr0_addr == addr);
    assign hit1    = wr1_en && (wr1_addr == addr);
    assign set_hit = set_en && (set_addr == addr);

    always_comb begin
        data = regs[addr];
        busy = busy_vec[addr];
        if (BYPASS) begin
            if (hit1) begin
                data = wr1_data;
            end else if (hit0) begin
                data = wr0_data;
            end
            // A write retires the producer unless a new one issues now
            if ((hit0 || hit1) && !set_hit) begin
                busy = 1'b0;
            end
        end
        if (R0_ZERO && (addr == '0)) begin
            data = '0;
            busy = 1'b0;
        end
    end

endmodule

// File: rtl/reg_file_2r2w_sb.sv
// Register file with two write ports, two read ports and a per-register
// busy scoreboard; wr1 beats wr0 and a busy set beats a write clear.
module reg_file_2r2w_sb
    import rf_pkg::*;
#(
    parameter int DATA_W  = DATA_W_DEF,
    parameter int ADDR_W  = ADDR_W_DEF,
    parameter bit R0_ZERO = 1'b0,
    parameter bit BYPASS  = 1'b1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              wr0_en,
    input  logic [ADDR_W-1:0] wr0_addr,
    input  logic [DATA_W-1:0] wr0_data,
    input  logic              wr1_en,
    input  logic [ADDR_W-1:0] wr1_addr,
    input  logic [DATA_W-1:0] wr1_data,
    input  logic [ADDR_W-1:0] rd0_addr,
    input  logic [ADDR_W-1:0] rd1_addr,
    output logic [DATA_W-1:0] rd0_data,
    output logic [DATA_W-1:0] rd1_data,
    output logic              rd0_busy,
    output logic              rd1_busy,
    input  logic              bsy_set_en,
    input  logic [ADDR_W-1:0] bsy_set_addr
);

    localparam int DEPTH = rf_depth(ADDR_W);

    logic [DEPTH-1:0][DATA_W-1:0] regs_q;
    logic [DEPTH-1:0]             busy_q;

    logic wr0_ok;
    logic wr1_ok;
    logic set_ok;

    // Register 0 never accepts writes or busy marks when hardwired
    assign wr0_ok = wr0_en && !(R0_ZERO && (wr0_addr == '0));
    assign wr1_ok = wr1_en && !(R0_ZERO && (wr1_addr == '0));
    assign set_ok = bsy_set_en && !(R0_ZERO && (bsy_set_addr == '0));

    always_ff @(posedge clk) begin
        if (rst) begin
            regs_q <= '0;
            busy_q <= '0;
        end else begin
            if (wr0_ok) regs_q[wr0_addr] <= wr0_data;
            if (wr1_ok) regs_q[wr1_addr] <= wr1_data;
            if (wr0_ok) busy_q[wr0_addr] <= 1'b0;
            if (wr1_ok) busy_q[wr1_addr] <= 1'b0;
            if (set_ok) busy_q[bsy_set_addr] <= 1'b1;
        end
    end

    rf_read_port #(
        .DATA_W  (DATA_W),
        .ADDR_W  (ADDR_W),
        .R0_ZERO (R0_ZERO),
        .BYPASS  (BYPASS),
        .DEPTH   (DEPTH)
    ) u_rd0 (
        .regs     (regs_q),
        .busy_vec (busy_q),
        .addr     (rd0_addr),
        .wr0_en   (wr0_ok),
        .wr0_addr (wr0_addr),
        .wr0_data (wr0_data),
        .wr1_en   (wr1_ok),
        .wr1_addr (wr1_addr),
        .wr1_data (wr1_data),
        .set_en   (set_ok),
        .set_addr (bsy_set_addr),
        .data     (rd0_data),
        .busy     (rd0_busy)
    );

    rf_read_port #(
        .DATA_W  (DATA_W),
        .ADDR_W  (ADDR_W),
        .R0_ZERO (R0_ZERO),
        .BYPASS  (BYPASS),
        .DEPTH   (DEPTH)
    ) u_rd1 (
        .regs     (regs_q),
        .busy_vec (busy_q),
        .addr     (rd1_addr),
        .wr0_en   (wr0_ok),
        .wr0_addr (wr0_addr),
        .wr0_data (wr0_data),
        .wr1_en   (wr1_ok),
        .wr1_addr (wr1_addr),
        .wr1_data (wr1_data),
        .set_en   (set_ok),
        .set_addr (bsy_set_addr),
        .data     (rd1_data),
        .busy     (rd1_busy)
    );

endmodule

// File: tb/tb_reg_file_2r2w_sb.sv
// Directed bench: three instances (default, BYPASS=0, R0_ZERO=1)
// share one stimulus stream.
module tb_reg_file_2r2w_sb;

    logic        clk;
    logic        rst;
    logic        wr0_en;
    logic [2:0]  wr0_addr;
    logic [15:0] wr0_data;
    logic        wr1_en;
    logic [2:0]  wr1_addr;
    logic [15:0] wr1_data;
    logic [2:0]  rd0_addr;
    logic [2:0]  rd1_addr;
    logic        bsy_set_en;
    logic [2:0]  bsy_set_addr;

    logic [15:0] d_rd0, d_rd1, n_rd0, n_rd1, z_rd0, z_rd1;
    logic        d_b0, d_b1, n_b0, n_b1, z_b0, z_b1;

    int checks = 0;
    int errors = 0;

    reg_file_2r2w_sb u_dut (
        .clk(clk), .rst(rst),
        .wr0_en(wr0_en), .wr0_addr(wr0_addr), .wr0_data(wr0_data),
        .wr1_en(wr1_en), .wr1_addr(wr1_addr), .wr1_data(wr1_data),
        .rd0_addr(rd0_addr), .rd1_addr(rd1_addr),
        .rd0_data(d_rd0), .rd1_data(d_rd1),
        .rd0_busy(d_b0), .rd1_busy(d_b1),
        .bsy_set_en(bsy_set_en), .bsy_set_addr(bsy_set_addr)
    );

    reg_file_2r2w_sb #(.BYPASS(1'b0)) u_nb (
        .clk(clk), .rst(rst),
        .wr0_en(wr0_en), .wr0_addr(wr0_addr), .wr0_data(wr0_data),
        .wr1_en(wr1_en), .wr1_addr(wr1_addr), .wr1_data(wr1_data),
        .rd0_addr(rd0_addr), .rd1_addr(rd1_addr),
        .rd0_data(n_rd0), .rd1_data(n_rd1),
        .rd0_busy(n_b0), .rd1_busy(n_b1),
        .bsy_set_en(bsy_set_en), .bsy_set_addr(bsy_set_addr)
    );

    reg_file_2r2w_sb #(.R0_ZERO(1'b1)) u_z (
        .clk(clk), .rst(rst),
        .wr0_en(wr0_en), .wr0_addr(wr0_addr), .wr0_data(wr0_data),
        .wr1_en(wr1_en), .wr1_addr(wr1_addr), .wr1_data(wr1_data),
        .rd0_addr(rd0_addr), .rd1_addr(rd1_addr),
        .rd0_data(z_rd0), .rd1_data(z_rd1),
        .rd0_busy(z_b0), .rd1_busy(z_b1),
        .bsy_set_en(bsy_set_en), .bsy_set_addr(bsy_set_addr)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [15:0] obs,
                       input logic [15:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        wr0_en = 1'b0; wr0_addr = '0; wr0_data = '0;
        wr1_en = 1'b0; wr1_addr = '0; wr1_data = '0;
        bsy_set_en = 1'b0; bsy_set_addr = '0;
    endtask

    initial begin
        idle();
        rd0_addr = '0;
        rd1_addr = '0;
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;

        // after reset every address reads zero / not busy
        for (int a = 0; a < 8; a++) begin
            rd0_addr = 3'(a);
            rd1_addr = 3'(7 - a);
            #1;
            chk($sformatf("rst_rd0_data_%0d", a), d_rd0, 16'h0000);
            chk($sformatf("rst_rd1_data_%0d", a), d_rd1, 16'h0000);
            chk($sformatf("rst_rd0_busy_%0d", a), {15'b0, d_b0}, 16'h0);
            chk($sformatf("rst_rd1_busy_%0d", a), {15'b0, d_b1}, 16'h0);
        end

        // dual write to r3: wr1 wins
        wr0_en = 1'b1; wr0_addr = 3'd3; wr0_data = 16'hBEEF;
        wr1_en = 1'b1; wr1_addr = 3'd3; wr1_data = 16'h1234;
        tick();
        idle();
        rd0_addr = 3'd3;
        #1;
        chk("wr1_wins_dut", d_rd0, 16'h1234);
        chk("wr1_wins_nb", n_rd0, 16'h1234);
        chk("wr1_wins_z", z_rd0, 16'h1234);

        // same-cycle forwarding of r5
        wr0_en = 1'b1; wr0_addr = 3'd5; wr0_data = 16'hA5A5;
        rd0_addr = 3'd5;
        #1;
        chk("bypass_r5", d_rd0, 16'hA5A5);
        chk("nobypass_r5_old", n_rd0, 16'h0000);
        tick();
        idle();
        #1;
        chk("nobypass_r5_new", n_rd0, 16'hA5A5);
        chk("bypass_r5_stored", d_rd0, 16'hA5A5);

        // busy set then cleared by a write to r2
        bsy_set_en = 1'b1; bsy_set_addr = 3'd2;
        tick();
        idle();
        rd1_addr = 3'd2;
        #1;
        chk("busy_r2_set", {15'b0, d_b1}, 16'h1);
        chk("busy_r2_set_nb", {15'b0, n_b1}, 16'h1);
        wr0_en = 1'b1; wr0_addr = 3'd2; wr0_data = 16'h0042;
        #1;
        chk("busy_r2_bypass", {15'b0, d_b1}, 16'h0);
        chk("data_r2_bypass", d_rd1, 16'h0042);
        chk("busy_r2_nobypass", {15'b0, n_b1}, 16'h1);
        chk("data_r2_nobypass", n_rd1, 16'h0000);
        tick();
        idle();
        #1;
        chk("busy_r2_clr", {15'b0, d_b1}, 16'h0);
        chk("data_r2", d_rd1, 16'h0042);
        chk("busy_r2_clr_nb", {15'b0, n_b1}, 16'h0);
        chk("data_r2_nb", n_rd1, 16'h0042);

        // set and write r6 together: set wins
        bsy_set_en = 1'b1; bsy_set_addr = 3'd6;
        wr1_en = 1'b1; wr1_addr = 3'd6; wr1_data = 16'h1111;
        rd0_addr = 3'd6;
        tick();
        idle();
        #1;
        chk("busy_r6_setwins", {15'b0, d_b0}, 16'h1);
        chk("data_r6", d_rd0, 16'h1111);

        // write/set r0: hardwired only in u_z
        wr0_en = 1'b1; wr0_addr = 3'd0; wr0_data = 16'hFFFF;
        bsy_set_en = 1'b1; bsy_set_addr = 3'd0;
        rd0_addr = 3'd0;
        #1;
        chk("r0_zero_bypass", z_rd0, 16'h0000);
        chk("r0_norm_bypass", d_rd0, 16'hFFFF);
        tick();
        idle();
        #1;
        chk("r0_zero_data", z_rd0, 16'h0000);
        chk("r0_zero_busy", {15'b0, z_b0}, 16'h0);
        chk("r0_norm_data", d_rd0, 16'hFFFF);
        chk("r0_norm_busy", {15'b0, d_b0}, 16'h1);

        // mark r1, r4 busy then reset with concurrent write/set
        bsy_set_en = 1'b1; bsy_set_addr = 3'd1;
        tick();
        bsy_set_addr = 3'd4;
        tick();
        idle();
        rd0_addr = 3'd1;
        rd1_addr = 3'd4;
        #1;
        chk("pre_rst_busy_r1", {15'b0, d_b0}, 16'h1);
        chk("pre_rst_busy_r4", {15'b0, d_b1}, 16'h1);
        rst = 1'b1;
        wr0_en = 1'b1; wr0_addr = 3'd1; wr0_data = 16'h7777;
        bsy_set_en = 1'b1; bsy_set_addr = 3'd4;
        tick();
        rst = 1'b0;
        idle();
        for (int a = 0; a < 8; a++) begin
            rd0_addr = 3'(a);
            rd1_addr = 3'(a);
            #1;
            chk($sformatf("mid_rst_data_%0d", a), d_rd0, 16'h0000);
            chk($sformatf("mid_rst_busy_%0d", a), {15'b0, d_b1}, 16'h0);
            chk($sformatf("mid_rst_nb_data_%0d", a), n_rd1, 16'h0000);
            chk($sformatf("mid_rst_nb_busy_%0d", a), {15'b0, n_b0}, 16'h0);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
